// File: rtl/multicycle_control_unit_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mips_defs : opcode, ALUOp, mux encodings and FSM state codes. Rev 1.0
// ---------------------------------------------------------------------------
package mips_defs;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALUOP_RTYPE = 3'b111;
    localparam logic [2:0] ALUOP_ADD   = 3'b100;
    localparam logic [2:0] ALUOP_OR    = 3'b101;
    localparam logic [2:0] ALUOP_LUI   = 3'b110;
    localparam logic [2:0] ALUOP_IDLE  = 3'b000;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_SEXT = 2'b10;
    localparam logic [1:0] SRCB_ZEXT = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_EXEC_R    = 4'd2,
        S_WB_R      = 4'd3,
        S_EXEC_I    = 4'd4,
        S_WB_I      = 4'd5,
        S_MEM_ADDR  = 4'd6,
        S_MEM_READ  = 4'd7,
        S_MEM_WB    = 4'd8,
        S_MEM_WRITE = 4'd9,
        S_JUMP      = 4'd10,
        S_TRAP      = 4'd11
    } state_t;

    // Sub-op kept past DECODE so later states never look at the live opcode.
    typedef enum logic [2:0] {
        SUB_NONE = 3'd0,
        SUB_ADDI = 3'd1,
        SUB_ORI  = 3'd2,
        SUB_LUI  = 3'd3,
        SUB_LW   = 3'd4,
        SUB_SW   = 3'd5
    } subop_t;

endpackage
`default_nettype wire

// File: rtl/multicycle_control_unit_decoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// multicycle_opcode_decoder : opcode -> post-DECODE state and sub-op. Rev 1.0
// ---------------------------------------------------------------------------
module multicycle_opcode_decoder
    import mips_defs::*;
(
    input  logic [5:0] opcode_i,
    output state_t     next_state_o,
    output subop_t     subop_o
);

    always_comb begin
        next_state_o = S_TRAP;
        subop_o      = SUB_NONE;
        case (opcode_i)
            OP_RTYPE: next_state_o = S_EXEC_R;
            OP_ADDI:  begin next_state_o = S_EXEC_I;   subop_o = SUB_ADDI; end
            OP_ORI:   begin next_state_o = S_EXEC_I;   subop_o = SUB_ORI;  end
            OP_LUI:   begin next_state_o = S_EXEC_I;   subop_o = SUB_LUI;  end
            OP_LW:    begin next_state_o = S_MEM_ADDR; subop_o = SUB_LW;   end
            OP_SW:    begin next_state_o = S_MEM_ADDR; subop_o = SUB_SW;   end
            OP_J:     next_state_o = S_JUMP;
            default:  next_state_o = S_TRAP;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// multicycle_control_unit : main control FSM of the multicycle MIPS datapath.
// Rev 1.0
// ---------------------------------------------------------------------------
module multicycle_control_unit
    import mips_defs::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       MemRead,
    output logic       IorD,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [2:0] ALUOp,
    output logic       retire,
    output logic       illegal_op
);

    state_t state_q, state_d;
    subop_t subop_q, subop_d;
    state_t w_dec_state;
    subop_t w_dec_subop;

    multicycle_opcode_decoder u_dec (
        .opcode_i     (opcode),
        .next_state_o (w_dec_state),
        .subop_o      (w_dec_subop)
    );

    always_comb begin
        state_d = state_q;
        subop_d = subop_q;
        case (state_q)
            S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                state_d = w_dec_state;
                subop_d = w_dec_subop;
            end
            S_EXEC_R:    state_d = S_WB_R;
            S_WB_R:      state_d = S_FETCH;
            S_EXEC_I:    state_d = S_WB_I;
            S_WB_I:      state_d = S_FETCH;
            S_MEM_ADDR:  state_d = (subop_q == SUB_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB:    state_d = S_FETCH;
            S_MEM_WRITE: state_d = mem_ready ? S_FETCH : S_MEM_WRITE;
            S_JUMP:      state_d = S_FETCH;
            S_TRAP:      state_d = S_TRAP;
            default:     state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            subop_q <= SUB_NONE;
        end else begin
            state_q <= state_d;
            subop_q <= subop_d;
        end
    end

    always_comb begin
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        MemRead    = 1'b0;
        IorD       = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_REG;
        PCSource   = PCSRC_ALU;
        ALUOp      = ALUOP_IDLE;
        retire     = 1'b0;
        illegal_op = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                ALUOp   = ALUOP_ADD;
                PCWrite = mem_ready;
                IRWrite = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB = SRCB_SEXT;
                ALUOp   = ALUOP_ADD;
            end
            S_EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_RTYPE;
            end
            S_WB_R: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                retire   = 1'b1;
            end
            S_EXEC_I: begin
                ALUSrcA = 1'b1;
                case (subop_q)
                    SUB_ORI: begin ALUSrcB = SRCB_ZEXT; ALUOp = ALUOP_OR;  end
                    SUB_LUI: begin ALUSrcB = SRCB_ZEXT; ALUOp = ALUOP_LUI; end
                    default: begin ALUSrcB = SRCB_SEXT; ALUOp = ALUOP_ADD; end
                endcase
            end
            S_WB_I: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_SEXT;
                ALUOp   = ALUOP_ADD;
            end
            S_MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                retire   = 1'b1;
            end
            S_MEM_WRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                retire   = mem_ready;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = PCSRC_JUMP;
                retire   = 1'b1;
            end
            S_TRAP:  illegal_op = 1'b1;
            default: ;
        endcase
        // Reset kills every write/retire immediately, even mid-cycle.
        if (!reset) begin
            PCWrite    = 1'b0;
            IRWrite    = 1'b0;
            RegWrite   = 1'b0;
            MemWrite   = 1'b0;
            retire     = 1'b0;
            illegal_op = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_multicycle_control_unit : directed + random bench with step-index model.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_multicycle_control_unit;

    localparam int K_R = 0, K_ADDI = 1, K_ORI = 2, K_LUI = 3;
    localparam int K_LW = 4, K_SW = 5, K_J = 6, K_ILL = 7;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite, IRWrite, RegWrite, MemWrite, MemRead, IorD;
    logic       RegDst, MemtoReg, ALUSrcA, retire, illegal_op;
    logic [1:0] ALUSrcB, PCSource;
    logic [2:0] ALUOp;

    int checks = 0;
    int passed = 0;
    int m_kind = K_R;
    int m_k    = 0;
    int cyc_n  = 0;
    int pcw_cnt, irw_cnt, ret_cnt, last_ret;
    logic [5:0] cur_op;
    logic [5:0] legal_ops [7];

    multicycle_control_unit dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .MemRead    (MemRead),
        .IorD       (IorD),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .PCSource   (PCSource),
        .ALUOp      (ALUOp),
        .retire     (retire),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    function automatic logic [17:0] pk(
        input logic pcw, irw, rw, mw, mr, iord, rd, m2r, sa,
        input logic [1:0] sb, input logic [1:0] pcs, input logic [2:0] aop,
        input logic ret, ill);
        return {pcw, irw, rw, mw, mr, iord, rd, m2r, sa, sb, pcs, aop, ret, ill};
    endfunction

    function automatic logic [17:0] observed();
        return {PCWrite, IRWrite, RegWrite, MemWrite, MemRead, IorD, RegDst,
                MemtoReg, ALUSrcA, ALUSrcB, PCSource, ALUOp, retire, illegal_op};
    endfunction

    function automatic int kind_of(input logic [5:0] op);
        case (op)
            6'b000000: return K_R;
            6'b001000: return K_ADDI;
            6'b001101: return K_ORI;
            6'b001111: return K_LUI;
            6'b100011: return K_LW;
            6'b101011: return K_SW;
            6'b000010: return K_J;
            default:   return K_ILL;
        endcase
    endfunction

    function automatic int last_step(input int kind);
        case (kind)
            K_LW:    return 4;
            K_J:     return 2;
            default: return 3;
        endcase
    endfunction

    // Expected outputs from instruction kind and step index inside it.
    function automatic logic [17:0] model_out(input int kind, input int k, input logic rdy);
        if (k == 0) return pk(rdy, rdy, 0, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 3'b100, 0, 0);
        if (k == 1) return pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 3'b100, 0, 0);
        case (kind)
            K_R:    return (k == 2) ? pk(0,0,0,0,0,0,0,0,1, 2'b00, 2'b00, 3'b111, 0, 0)
                                    : pk(0,0,1,0,0,0,1,0,0, 2'b00, 2'b00, 3'b000, 1, 0);
            K_ADDI: return (k == 2) ? pk(0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 3'b100, 0, 0)
                                    : pk(0,0,1,0,0,0,0,0,0, 2'b00, 2'b00, 3'b000, 1, 0);
            K_ORI:  return (k == 2) ? pk(0,0,0,0,0,0,0,0,1, 2'b11, 2'b00, 3'b101, 0, 0)
                                    : pk(0,0,1,0,0,0,0,0,0, 2'b00, 2'b00, 3'b000, 1, 0);
            K_LUI:  return (k == 2) ? pk(0,0,0,0,0,0,0,0,1, 2'b11, 2'b00, 3'b110, 0, 0)
                                    : pk(0,0,1,0,0,0,0,0,0, 2'b00, 2'b00, 3'b000, 1, 0);
            K_LW: begin
                if (k == 2) return pk(0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 3'b100, 0, 0);
                if (k == 3) return pk(0,0,0,0,1,1,0,0,0, 2'b00, 2'b00, 3'b000, 0, 0);
                return pk(0,0,1,0,0,0,0,1,0, 2'b00, 2'b00, 3'b000, 1, 0);
            end
            K_SW:   return (k == 2) ? pk(0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 3'b100, 0, 0)
                                    : pk(0,0,0,1,0,1,0,0,0, 2'b00, 2'b00, 3'b000, rdy, 0);
            K_J:    return pk(1,0,0,0,0,0,0,0,0, 2'b00, 2'b10, 3'b000, 1, 0);
            default: return pk(0,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 3'b000, 0, 1);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) passed++;
        else $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc_n, obs, expv);
    endtask

    task automatic cyc(input logic rdy, input logic [5:0] op);
        logic stall;
        @(negedge clk);
        mem_ready = rdy;
        opcode    = op;
        #1;
        cyc_n++;
        if (m_k == 1) m_kind = kind_of(op);
        check("outputs", {14'd0, observed()}, {14'd0, model_out(m_kind, m_k, rdy)});
        if (PCWrite) pcw_cnt++;
        if (IRWrite) irw_cnt++;
        if (retire) begin ret_cnt++; last_ret = cyc_n; end
        stall = (m_k == 0) || ((m_kind == K_LW || m_kind == K_SW) && m_k == 3);
        if (stall && !rdy) m_k = m_k;
        else if (m_kind == K_ILL && m_k >= 2) m_k = m_k;
        else if (m_k >= 2 && m_k == last_step(m_kind)) m_k = 0;
        else m_k = m_k + 1;
    endtask

    // Asserted at an arbitrary point inside a cycle; outputs must react at once.
    task automatic do_reset();
        reset = 1'b0;
        #1;
        check("reset_state", {14'd0, observed()},
              {14'd0, pk(0,0,0,0,1,0,0,0,0, 2'b01, 2'b00, 3'b100, 0, 0)});
        mem_ready = ~mem_ready;
        #1;
        check("reset_forced", {14'd0, observed()},
              {14'd0, pk(0,0,0,0,1,0,0,0,0, 2'b01, 2'b00, 3'b100, 0, 0)});
        mem_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        m_k   = 0;
    endtask

    task automatic clr_cnt();
        pcw_cnt = 0; irw_cnt = 0; ret_cnt = 0; last_ret = 0; cyc_n = 0;
    endtask

    initial begin
        legal_ops = '{6'b000000, 6'b001000, 6'b001101, 6'b001111,
                      6'b100011, 6'b101011, 6'b000010};
        reset = 1'b0; mem_ready = 1'b0; opcode = 6'd0;
        #2;
        do_reset();
        clr_cnt();

        // R-type add
        repeat (4) cyc(1'b1, 6'b000000);
        check("r_retire_cycle", last_ret, 4);
        check("r_retire_count", ret_cnt, 1);

        // lw with fetch and memory stalls
        clr_cnt();
        repeat (2) cyc(1'b0, 6'b100011);
        repeat (3) cyc(1'b1, 6'b100011);
        repeat (3) cyc(1'b0, 6'b100011);
        repeat (2) cyc(1'b1, 6'b100011);
        check("lw_latency", last_ret, 10);
        check("lw_pcwrite_once", pcw_cnt, 1);
        check("lw_irwrite_once", irw_cnt, 1);
        check("lw_last_m2r_rw", {30'd0, MemtoReg, RegWrite}, 32'd3);

        // ori then lui back to back
        clr_cnt();
        repeat (4) cyc(1'b1, 6'b001101);
        repeat (4) cyc(1'b1, 6'b001111);
        check("ori_lui_retires", ret_cnt, 2);

        // unsupported opcode traps until reset
        clr_cnt();
        repeat (23) cyc(1'($urandom_range(0, 1)), 6'b000100);
        check("trap_no_retire", ret_cnt, 0);
        check("trap_flag", {31'd0, illegal_op}, 32'd1);
        do_reset();
        repeat (4) cyc(1'b1, 6'b000000);

        // sw interrupted by reset in MEM_WRITE
        repeat (3) cyc(1'b1, 6'b101011);
        cyc(1'b0, 6'b101011);
        check("sw_memwrite_held", {31'd0, MemWrite}, 32'd1);
        do_reset();
        cyc(1'b0, 6'b000000);

        // j, followed by the next fetch
        clr_cnt();
        cyc(1'b1, 6'b000000);
        repeat (3) cyc(1'b1, 6'b000010);
        cyc(1'b1, 6'b001000);
        check("j_pcwrites", pcw_cnt, 3);
        repeat (3) cyc(1'b1, 6'b001000);

        // randomized traffic, opcode scrambled after DECODE
        for (int i = 0; i < 600; i++) begin
            if (m_k == 0) begin
                if ($urandom_range(0, 19) == 0) cur_op = 6'($urandom);
                else cur_op = legal_ops[$urandom_range(0, 6)];
            end
            if (m_kind == K_ILL && m_k >= 2 && $urandom_range(0, 3) == 0) begin
                @(negedge clk);
                #3;
                do_reset();
            end else begin
                cyc(($urandom_range(0, 3) != 0), (m_k >= 2) ? 6'($urandom) : cur_op);
            end
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
